// File: rtl/lza_norm_seq.sv
// Sequential leading-zero normalizer: scans the operand one byte at a time
// (MSB byte first) with a single 8-bit leading-zero counter, then left-shifts
// the captured operand by the accumulated count in a single SHIFT cycle.
module lza_norm_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mant,
   output logic [CW-1:0]    out_cnt,
   output logic             out_zero,
   output logic             busy
);

   localparam int unsigned NB = WIDTH / 8;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StScan  = 2'd1;
   localparam logic [1:0] StShift = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] out_mant_q, out_mant_d;
   logic [CW-1:0]    out_cnt_q, out_cnt_d;
   logic             out_zero_q, out_zero_d;

   logic [WIDTH-1:0] byte_aligned;
   logic [7:0]       cur_byte;
   logic [3:0]       byte_lz;
   logic             last_byte;

   // Select the byte under scan and count its leading zeros (8 when empty).
   always_comb begin
      byte_aligned = operand_q << {idx_q, 3'b000};
      cur_byte     = byte_aligned[WIDTH-1 -: 8];
      byte_lz      = 4'd8;
      // Ascending loop: the highest set bit is the last one to assign.
      for (int i = 0; i < 8; i++) begin
         if (cur_byte[i]) byte_lz = 4'(7 - i);
      end
      last_byte = (idx_q == IW'(NB - 1));
   end

   // Next-state and datapath update; flush overrides every state.
   always_comb begin
      state_d    = state_q;
      operand_d  = operand_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      out_mant_d = out_mant_q;
      out_cnt_d  = out_cnt_q;
      out_zero_d = out_zero_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  operand_d = in_mant;
                  idx_d     = '0;
                  acc_d     = '0;
                  state_d   = StScan;
               end
            end
            StScan: begin
               if (cur_byte != 8'd0) begin
                  acc_d   = acc_q + CW'(byte_lz);
                  state_d = StShift;
               end else if (!last_byte) begin
                  acc_d = acc_q + CW'(8);
                  idx_d = idx_q + IW'(1);
               end else begin
                  out_mant_d = '0;
                  out_cnt_d  = CW'(WIDTH);
                  out_zero_d = 1'b1;
                  state_d    = StDone;
               end
            end
            StShift: begin
               out_mant_d = operand_q << acc_q;
               out_cnt_d  = acc_q;
               out_zero_d = 1'b0;
               state_d    = StDone;
            end
            default: begin
               if (out_ready) state_d = StIdle;
            end
         endcase
      end
   end

   // State and result registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         operand_q  <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         out_mant_q <= '0;
         out_cnt_q  <= '0;
         out_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         operand_q  <= operand_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         out_mant_q <= out_mant_d;
         out_cnt_q  <= out_cnt_d;
         out_zero_q <= out_zero_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_mant  = out_mant_q;
   assign out_cnt   = out_cnt_q;
   assign out_zero  = out_zero_q;

endmodule

// File: doc/lza_norm_seq.md
LZA_NORM_SEQ -- requirements
Module: lza_norm_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; legal values are multiples of 8 from 16 to 64.
REQ-002 SHALL have parameter CW, default 6, meaning count width; CW SHALL equal clog2(WIDTH+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of the in-flight operation.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand.
REQ-008 SHALL have port in_mant, input, WIDTH bits: unnormalized mantissa.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_mant, output, WIDTH bits: normalized mantissa.
REQ-012 SHALL have port out_cnt, output, CW bits: leading-zero count, 0..WIDTH.
REQ-013 SHALL have port out_zero, output, 1 bit: the operand was all zeros.
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-015 SHALL use one 8-bit leading-zero counter, time-shared over operand bytes, scanning MSB byte first.
- The counter returns 0..8; all-zero input gives 8.
REQ-016 SHALL implement FSM states IDLE, SCAN, SHIFT and DONE.
REQ-017 In IDLE, SHALL drive in_ready=1.
- On in_valid&in_ready: capture in_mant, clear byte index and count accumulator, go to SCAN.
REQ-018 In SCAN, each cycle SHALL count leading zeros of byte[index], with index 0 being bits WIDTH-1:WIDTH-8.
REQ-019 In SCAN, if the byte is nonzero: accumulator += byte lz count, go to SHIFT.
REQ-020 In SCAN, if the byte is zero and it is not the last byte: accumulator += 8, index++.
REQ-021 In SCAN, if the byte is zero and it is the last byte: set out_cnt=WIDTH, out_mant=0, out_zero=1, go to DONE with no SHIFT.
REQ-022 SHIFT SHALL last one cycle: out_mant = captured operand logically shifted left by the accumulator, zero fill; out_cnt = accumulator; out_zero=0; then go to DONE.
REQ-023 In DONE, out_valid SHALL be 1; out_mant, out_cnt and out_zero SHALL hold stable until out_valid&out_ready; then go to IDLE.
REQ-024 in_ready SHALL be 0 in SCAN, SHIFT and DONE; a new operand is accepted only from IDLE, with no overlap.
REQ-025 Latency, with the accept edge counted as cycle 0:
- Nonzero operand whose first nonzero byte is k: out_valid SHALL rise in cycle k+3.
- Zero operand: out_valid SHALL rise in cycle WIDTH/8+1.
REQ-026 flush=1 in any state SHALL force IDLE at the next edge and deassert out_valid; the pending result is discarded.
REQ-027 flush and in_valid both high in IDLE: flush wins and no operand is captured.
REQ-028 flush together with an out handshake in DONE: the result counts as consumed and the next state is IDLE.
REQ-029 out_mant, out_cnt and out_zero SHALL retain their last values in IDLE; they are meaningful only while out_valid=1.
REQ-030 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-031 While rst_n=0, SHALL asynchronously set the following, mid-operation included:
- state=IDLE, in_ready=1, out_valid=0, busy=0;
- out_mant=0, out_cnt=0, out_zero=0;
- index=0, accumulator=0.
REQ-032 After rst_n deasserts, SHALL accept an operand on the first rising edge with in_valid=1; no in-flight operation survives reset.

Verification (WIDTH=32)
REQ-033 in_mant=0x80000000 -> out_valid in cycle 3; out_mant=0x80000000, out_cnt=0, out_zero=0.
REQ-034 in_mant=0x00000001 -> out_valid in cycle 6; out_mant=0x80000000, out_cnt=31.
REQ-035 in_mant=0x00000000 -> out_valid in cycle 5; out_mant=0, out_cnt=32, out_zero=1.
REQ-036 in_mant=0x00012345 with out_ready=0 for 4 cycles -> out_mant=0x91A28000, out_cnt=15, held stable; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-037 flush in the 2nd SCAN cycle of 0x00000001 -> IDLE next cycle, no out_valid; the next operand 0x40000000 gives out_cnt=1, out_mant=0x80000000.
REQ-038 rst_n low during SHIFT -> outputs immediately reset to REQ-031 values; the first operand after release completes normally.
